// File: rtl/key_expansion_seq.sv
// Iterative AES key schedule: expands a 128/192/256-bit key one 32-bit word per clock
// into an internal round-key buffer that the cipher reads combinationally by round index.

module aes_sbox (
    input  logic [7:0] byte_val,
    output logic [7:0] sub_val
);
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte, so the bit offset is 8*(255-byte_val).
    assign sub_val = SBOX_TABLE[{~byte_val, 3'b000} +: 8];
endmodule

module key_expansion_seq #(
    parameter int KEY_LEN = 128
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [KEY_LEN-1:0] key,
    input  logic [3:0]         rk_idx,
    output logic [127:0]       round_key,
    output logic               busy,
    output logic               done
);
    localparam int NK = KEY_LEN / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);
    localparam logic [5:0] NK_W      = 6'(NK);
    localparam logic [5:0] LAST_W    = 6'(NW - 1);
    localparam logic [2:0] KPOS_LAST = 3'(NK - 1);
    localparam logic [3:0] NR_W      = 4'(NR);

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t      state, state_next;
    logic [31:0] w [NW];
    logic [5:0]  i;
    logic [2:0]  kpos;
    logic [7:0]  rcon;
    logic        load, expand;
    logic [5:0]  prev_idx, back_idx, base;
    logic [31:0] prev_word, back_word, sub_in, sub_out, temp, new_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = EXPAND;
            EXPAND:  if (i == LAST_W) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == EXPAND);
        expand = (state == EXPAND);
        load   = (state == IDLE) && start;
    end

    // kpos shadows i mod Nk so no divider is needed for the Nk=6 case.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i    <= '0;
            kpos <= '0;
            rcon <= 8'h01;
            done <= 1'b0;
        end else if (load) begin
            i    <= NK_W;
            kpos <= '0;
            rcon <= 8'h01;
            done <= 1'b0;
        end else if (expand) begin
            i    <= i + 6'd1;
            kpos <= (kpos == KPOS_LAST) ? 3'd0 : kpos + 3'd1;
            if (kpos == 3'd0)
                rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            if (i == LAST_W)
                done <= 1'b1;
        end
    end

    always_comb begin
        prev_idx  = i - 6'd1;
        back_idx  = i - NK_W;
        prev_word = '0;
        back_word = '0;
        if (prev_idx <= LAST_W) prev_word = w[prev_idx];
        if (back_idx <= LAST_W) back_word = w[back_idx];
        sub_in = (kpos == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
        temp   = prev_word;
        if (kpos == 3'd0)
            temp = sub_out ^ {rcon, 24'h0};
        else if (NK == 8 && kpos == 3'd4)
            temp = sub_out;
        new_word = back_word ^ temp;
    end

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .byte_val (sub_in[8*b +: 8]),
            .sub_val  (sub_out[8*b +: 8])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NW; k++) w[k] <= '0;
        end else if (load) begin
            for (int k = 0; k < NK; k++) w[k] <= key[KEY_LEN-1-32*k -: 32];
        end else if (expand) begin
            w[i] <= new_word;
        end
    end

    always_comb begin
        base      = {rk_idx, 2'b00};
        round_key = '0;
        if (rk_idx <= NR_W)
            round_key = {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
    end
endmodule

// File: tb/tb_key_expansion_seq.sv
// Directed bench for key_expansion_seq: one instance per key length, checked against FIPS-197 vectors.

module tb_key_expansion_seq;
    logic         clk = 1'b0;
    logic         reset;
    logic         start128, start192, start256;
    logic [127:0] key128;
    logic [191:0] key192;
    logic [255:0] key256;
    logic [3:0]   rk128, rk192, rk256;
    logic [127:0] out128, out192, out256;
    logic         busy128, busy192, busy256;
    logic         done128, done192, done256;

    int checks   = 0;
    int failures = 0;
    int lat, busyCnt;
    logic [127:0] rdata;

    always #5 clk = ~clk;

    key_expansion_seq #(.KEY_LEN(128)) dut128 (
        .clk(clk), .reset(reset), .start(start128), .key(key128), .rk_idx(rk128),
        .round_key(out128), .busy(busy128), .done(done128));

    key_expansion_seq #(.KEY_LEN(192)) dut192 (
        .clk(clk), .reset(reset), .start(start192), .key(key192), .rk_idx(rk192),
        .round_key(out192), .busy(busy192), .done(done192));

    key_expansion_seq #(.KEY_LEN(256)) dut256 (
        .clk(clk), .reset(reset), .start(start256), .key(key256), .rk_idx(rk256),
        .round_key(out256), .busy(busy256), .done(done256));

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic getBusy(input int sel);
        case (sel)
            0:       return busy128;
            1:       return busy192;
            default: return busy256;
        endcase
    endfunction

    function automatic logic getDone(input int sel);
        case (sel)
            0:       return done128;
            1:       return done192;
            default: return done256;
        endcase
    endfunction

    // Start pulse spans one rising edge; returns at the negedge right after it.
    task automatic applyStimulus(input int sel);
        @(negedge clk);
        case (sel)
            0:       start128 = 1'b1;
            1:       start192 = 1'b1;
            default: start256 = 1'b1;
        endcase
        @(negedge clk);
        start128 = 1'b0;
        start192 = 1'b0;
        start256 = 1'b0;
    endtask

    task automatic waitDone(input int sel, output int edges, output int busyCycles);
        edges      = 0;
        busyCycles = getBusy(sel) ? 1 : 0;
        while (!getDone(sel) && edges < 200) begin
            @(negedge clk);
            edges++;
            if (getBusy(sel)) busyCycles++;
        end
    endtask

    task automatic readRound(input int sel, input int idx, output logic [127:0] data);
        case (sel)
            0:       rk128 = 4'(idx);
            1:       rk192 = 4'(idx);
            default: rk256 = 4'(idx);
        endcase
        #1;
        case (sel)
            0:       data = out128;
            1:       data = out192;
            default: data = out256;
        endcase
    endtask

    initial begin
        reset    = 1'b0;
        start128 = 1'b0;
        start192 = 1'b0;
        start256 = 1'b0;
        key128   = 128'h000102030405060708090a0b0c0d0e0f;
        key192   = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
        key256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        rk128    = 4'd0;
        rk192    = 4'd0;
        rk256    = 4'd0;
        #1;
        checkOutput("reset_busy", 128'(busy128), 128'd0);
        checkOutput("reset_done", 128'(done128), 128'd0);
        checkOutput("reset_rk0", out128, 128'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // AES-128 reference key
        applyStimulus(0);
        key128 = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        waitDone(0, lat, busyCnt);
        checkOutput("aes128_latency", 128'(lat), 128'd40);
        checkOutput("aes128_busy_cycles", 128'(busyCnt), 128'd40);
        checkOutput("aes128_done", 128'(done128), 128'd1);
        readRound(0, 0, rdata);  checkOutput("aes128_rk0", rdata, 128'h000102030405060708090a0b0c0d0e0f);
        readRound(0, 1, rdata);  checkOutput("aes128_rk1", rdata, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        readRound(0, 2, rdata);  checkOutput("aes128_rk2", rdata, 128'hb692cf0b643dbdf1be9bc5006830b3fe);
        readRound(0, 10, rdata); checkOutput("aes128_rk10", rdata, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        readRound(0, 11, rdata); checkOutput("aes128_rk11", rdata, 128'h0);

        // Restart from done with a second key, then a start during the run that must be ignored
        key128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        applyStimulus(0);
        checkOutput("restart_done_drop", 128'(done128), 128'd0);
        checkOutput("restart_busy", 128'(busy128), 128'd1);
        repeat (9) @(negedge clk);
        key128   = 128'h000102030405060708090a0b0c0d0e0f;
        start128 = 1'b1;
        @(negedge clk);
        start128 = 1'b0;
        waitDone(0, lat, busyCnt);
        checkOutput("ignore_latency", 128'(lat + 10), 128'd40);
        readRound(0, 1, rdata);  checkOutput("key2_rk1", rdata, 128'ha0fafe1788542cb123a339392a6c7605);
        readRound(0, 10, rdata); checkOutput("key2_rk10", rdata, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // AES-192
        applyStimulus(1);
        waitDone(1, lat, busyCnt);
        checkOutput("aes192_latency", 128'(lat), 128'd46);
        readRound(1, 1, rdata);  checkOutput("aes192_rk1", rdata, 128'h10111213141516175846f2f95c43f4fe);
        readRound(1, 12, rdata); checkOutput("aes192_rk12", rdata, 128'ha4970a331a78dc09c418c271e3a41d5d);

        // AES-256
        applyStimulus(2);
        waitDone(2, lat, busyCnt);
        checkOutput("aes256_latency", 128'(lat), 128'd52);
        readRound(2, 2, rdata);  checkOutput("aes256_rk2", rdata, 128'ha573c29fa176c498a97fce93a572c09c);
        readRound(2, 14, rdata); checkOutput("aes256_rk14", rdata, 128'h24fc79ccbf0979e9371ac23c6d68de36);

        // Asynchronous reset in the middle of an AES-128 expansion
        key128 = 128'h000102030405060708090a0b0c0d0e0f;
        rk128  = 4'd0;
        applyStimulus(0);
        repeat (19) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset_busy", 128'(busy128), 128'd0);
        checkOutput("async_reset_done", 128'(done128), 128'd0);
        checkOutput("async_reset_rk0", out128, 128'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("post_reset_idle", 128'(busy128), 128'd0);
        applyStimulus(0);
        waitDone(0, lat, busyCnt);
        checkOutput("post_reset_latency", 128'(lat), 128'd40);
        readRound(0, 10, rdata); checkOutput("post_reset_rk10", rdata, 128'h13111d7fe3944a17f307a78b4d2b30c5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/key_expansion_seq.md
# key_expansion_seq

Iterative AES key-schedule generator that sits directly upstream of the `Cipher` datapath. It captures a cipher key on a start pulse and produces the FIPS-197 expanded key schedule at one 32-bit word per clock. It stores every round key in an internal buffer. The cipher reads each round key by round index once `done` is high.

## Interface
- `KEY_LEN`, default 128: key length in bits; legal values are 128, 192 and 256. Derived values:
  - Nk = KEY_LEN/32.
  - Nr = Nk+6.
  - Total words W = 4*(Nr+1), i.e. 44, 52 or 60.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle request to expand `key`.
- `key` input KEY_LEN: cipher key. Bits [KEY_LEN-1 -: 32] form w[0], MSB-first (FIPS byte order).
- `rk_idx` input 4: round index 0..Nr to read.
- `round_key` output 128: {w[4r], w[4r+1], w[4r+2], w[4r+3]} for r = `rk_idx`, with w[4r] in bits [127:96].
- `busy` output 1: expansion in progress.
- `done` output 1: complete schedule is valid in the buffer.

## Operation
- Word buffer holds W x 32 bits. The block also holds a word counter `i` (6 bits), a Rcon byte register and a two-state FSM with states IDLE and EXPAND.
- IDLE:
  - `start`=1 loads `key` into w[0..Nk-1].
  - Sets `i`=Nk and Rcon=8'h01.
  - Clears `done`, sets `busy` and moves to EXPAND.
- EXPAND: each cycle writes w[i] and increments `i`. Write rule with temp = w[i-1]:
  - If i mod Nk = 0: temp = SubWord(RotWord(temp)) XOR {Rcon, 24'h0}. After use, Rcon advances by xtime: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
  - Else if Nk = 8 and i mod 8 = 4: temp = SubWord(temp).
  - w[i] = w[i-Nk] XOR temp.
- When w[W-1] is written, the FSM returns to IDLE, `busy` goes to 0 and `done` goes to 1.
- SubWord applies the FIPS-197 S-box to the 4 bytes. The S-box is a local combinational lookup and needs 4 instances.
- `round_key` is a combinational read of the buffer.
  - For `rk_idx` > Nr it returns 128'h0.
  - While `busy`=1 it returns current buffer contents; these are only guaranteed valid when `done`=1.
- A `start` while `busy`=1 is ignored; the expansion in progress continues unchanged.
- A `start` while `done`=1 restarts the expansion: `done` drops on that edge and the new key is loaded.
- `key` is sampled only on the `start` edge. Later changes to `key` have no effect.

## Timing
- Reset (`reset`=0, asynchronous) sets:
  - `busy`=0, `done`=0.
  - FSM=IDLE, `i`=0, Rcon=8'h01.
  - All buffer words = 0, so `round_key`=0.
- Reset mid-expansion aborts immediately, and the block stays idle after release until the next `start`.
- Edge E0 samples `start`=1. Words w[Nk]..w[W-1] are written on edges E1..E(W-Nk).
- `done`=1 and `busy`=0 become visible after edge E(W-Nk). Latency is 40, 46 or 52 cycles for KEY_LEN 128, 192 or 256.
- `round_key` follows `rk_idx` with no register delay. The cipher may present `rk_idx` and use `round_key` in the same cycle.
- Throughput is one key per W-Nk+1 cycles when `start` is re-issued on the first cycle `done` is high.

## Test plan
- AES-128 functional: KEY_LEN=128, key 000102030405060708090a0b0c0d0e0f, `start` for 1 cycle.
  - `busy` must be high for exactly 40 cycles, then `done`=1.
  - rk_idx=0 must give 000102030405060708090a0b0c0d0e0f.
  - rk_idx=1 must give d6aa74fdd2af72fadaa678f1d6ab76fe.
  - rk_idx=10 must give 13111d7fe3944a17f307a78b4d2b30c5.
  - rk_idx=11 must give 0.
- Second AES-128 key: key 2b7e151628aed2a6abf7158809cf4f3c; rk_idx=10 must give d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192: KEY_LEN=192, key 000102...1617.
  - `done` must rise after 46 cycles.
  - rk_idx=12 must give a4970a331a78dc09c418c271e3a41d5d.
- AES-256: KEY_LEN=256, key 000102...1e1f.
  - `done` must rise after 52 cycles.
  - rk_idx=14 must give 24fc79ccbf0979e9371ac23c6d68de36. This checks the i mod 8 = 4 SubWord path.
- Start handling: assert `start` with a different key at cycle 10 of an expansion.
  - The block must ignore it; the first key's schedule must complete unchanged.
  - A `start` issued while `done`=1 must drop `done` on the next edge and produce the new schedule.
- Reset mid-operation: drive `reset`=0 asynchronously at cycle 20 of an expansion.
  - `busy`, `done` and `round_key` must go to 0 without waiting for a clock edge.
  - After release, a fresh `start` must produce the correct 128-bit schedule.
